// File: rtl/tile_absmax_buffer.sv
// Ping-pong tile buffer: accumulates NUM_BEATS beats, finds the tile magnitude maximum,
// then replays the tile with a constant max_num and a per-element outlier mask.
module tile_absmax_buffer #(
  parameter int unsigned IN_WIDTH       = 16,
  parameter int unsigned IN_SIZE        = 4,
  parameter int unsigned IN_PARALLELISM = 1,
  parameter int unsigned NUM_BEATS      = 4,
  parameter int unsigned MAX_MODE       = 1,
  parameter int unsigned MAX_NUM_WIDTH  = IN_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0] data_in,
  input  logic                                          data_in_valid,
  output logic                                          data_in_ready,
  input  logic [MAX_NUM_WIDTH-1:0]                      threshold,
  output logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0] data_out,
  output logic [IN_SIZE*IN_PARALLELISM-1:0]             outlier_mask,
  output logic                                          data_out_last,
  output logic                                          data_out_valid,
  input  logic                                          data_out_ready,
  output logic [MAX_NUM_WIDTH-1:0]                      max_num
);

  localparam int unsigned N     = IN_SIZE * IN_PARALLELISM;
  localparam int unsigned BeatW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned CmpW  = (MAX_NUM_WIDTH > IN_WIDTH) ? MAX_NUM_WIDTH : IN_WIDTH;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(NUM_BEATS - 1);

  typedef logic [N-1:0][IN_WIDTH-1:0] beat_t;

  // Magnitude with the most negative value saturating to the most positive.
  function automatic logic [IN_WIDTH-1:0] mag(input logic [IN_WIDTH-1:0] x);
    logic [IN_WIDTH-1:0] most_neg;
    most_neg = '0;
    most_neg[IN_WIDTH-1] = 1'b1;
    if (x == most_neg) begin
      mag = ~most_neg;
    end else if (x[IN_WIDTH-1]) begin
      mag = -x;
    end else begin
      mag = x;
    end
  endfunction

  beat_t                     mem_q [2][NUM_BEATS];
  logic [1:0]                full_q, full_d;
  logic [MAX_NUM_WIDTH-1:0]  max_q [2];
  logic [MAX_NUM_WIDTH-1:0]  thr_q [2];
  logic                      wbank_q, rbank_q;
  logic [BeatW-1:0]          wbeat_q, rbeat_q;
  logic signed [IN_WIDTH-1:0] run_q, run_d;
  logic signed [IN_WIDTH-1:0] beat_best, elem_val;
  logic [IN_WIDTH-1:0]       commit_mag;
  logic                      wr_en, wr_last, rd_en, rd_last;
  beat_t                     rd_beat;

  assign data_in_ready  = !full_q[wbank_q];
  assign data_out_valid = full_q[rbank_q];
  assign wr_en   = data_in_valid && data_in_ready;
  assign wr_last = wr_en && (wbeat_q == LastBeat);
  assign rd_en   = data_out_valid && data_out_ready;
  assign rd_last = rd_en && (rbeat_q == LastBeat);

  // MAX_MODE=1 reduces magnitudes; MAX_MODE=0 reduces signed values and takes |.| at commit.
  always_comb begin
    elem_val  = '0;
    beat_best = (MAX_MODE != 0) ? mag(data_in[0]) : data_in[0];
    for (int i = 1; i < N; i++) begin
      elem_val = (MAX_MODE != 0) ? mag(data_in[i]) : data_in[i];
      if (elem_val > beat_best) begin
        beat_best = elem_val;
      end
    end
    run_d      = ((wbeat_q == '0) || (beat_best > run_q)) ? beat_best : run_q;
    commit_mag = (MAX_MODE != 0) ? run_d : mag(run_d);
  end

  always_comb begin
    full_d = full_q;
    if (wr_last) begin
      full_d[wbank_q] = 1'b1;
    end
    if (rd_last) begin
      full_d[rbank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wbeat_q <= '0;
      rbeat_q <= '0;
      run_q   <= '0;
      max_q[0] <= '0;
      max_q[1] <= '0;
      thr_q[0] <= '0;
      thr_q[1] <= '0;
    end else begin
      full_q <= full_d;
      if (wr_en) begin
        run_q <= run_d;
        if (wbeat_q == '0) begin
          thr_q[wbank_q] <= threshold;
        end
        if (wr_last) begin
          max_q[wbank_q] <= MAX_NUM_WIDTH'(commit_mag);
          wbank_q        <= ~wbank_q;
          wbeat_q        <= '0;
        end else begin
          wbeat_q <= wbeat_q + 1'b1;
        end
      end
      if (rd_en) begin
        if (rd_last) begin
          rbank_q <= ~rbank_q;
          rbeat_q <= '0;
        end else begin
          rbeat_q <= rbeat_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wbank_q][wbeat_q] <= data_in;
    end
  end

  // Outputs are gated by valid so nothing undefined leaks out of an idle bank.
  always_comb begin
    rd_beat       = mem_q[rbank_q][rbeat_q];
    data_out      = data_out_valid ? rd_beat : '0;
    max_num       = data_out_valid ? max_q[rbank_q] : '0;
    data_out_last = data_out_valid && (rbeat_q == LastBeat);
    outlier_mask  = '0;
    for (int i = 0; i < N; i++) begin
      outlier_mask[i] = data_out_valid &&
                        (CmpW'(mag(rd_beat[i])) >= CmpW'(thr_q[rbank_q]));
    end
  end

endmodule
